// File: rtl/systolic_array_ctrl_if.sv
// systolic_array_ctrl_if: job, feed, result and status signals of the systolic array controller
// slave  (controller): takes i_valid/i_a/i_b, i_c, i_ready; drives o_ready, o_clear, o_doProcess, o_row, o_col, o_valid, o_c, o_busy
// master (job source, array and result sink): the mirror image
interface systolic_array_ctrl_if;
    logic                    i_valid;
    logic                    o_ready;
    logic [3:0][3:0][7:0]    i_a;
    logic [3:0][3:0][7:0]    i_b;
    logic                    o_clear;
    logic                    o_doProcess;
    logic [3:0][7:0]         o_row;
    logic [3:0][7:0]         o_col;
    logic [3:0][3:0][15:0]   i_c;
    logic                    o_valid;
    logic                    i_ready;
    logic [3:0][3:0][15:0]   o_c;
    logic                    o_busy;
    modport slave (
        input  i_valid, i_a, i_b, i_c, i_ready,
        output o_ready, o_clear, o_doProcess, o_row, o_col, o_valid, o_c, o_busy
    );
    modport master (
        output i_valid, i_a, i_b, i_c, i_ready,
        input  o_ready, o_clear, o_doProcess, o_row, o_col, o_valid, o_c, o_busy
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: job sequencer for a 4x4 8-bit systolic array (clear, skewed feed, drain, result hand-off)
// i_clk  : clock
// i_arst : synchronous active-high reset
// bus    : systolic_array_ctrl_if.slave carrying job handshake, edge feeds, PE results and result handshake
module systolic_array_ctrl #(
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    systolic_array_ctrl_if.slave  bus
);
    localparam int BEATS = 3 * N - 2;
    if (N != 4) begin : g_bad_n
        $fatal(1, "systolic_array_ctrl: N must be 4");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $fatal(1, "systolic_array_ctrl: DRAIN_CYCLES must be 1..15");
    end
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [3:0][3:0][7:0] a_q, b_q;
    logic [3:0][7:0]      row_n, col_n;
    logic                 last_beat, last_drain;
    int                   k;
    assign last_beat  = cnt == 4'(BEATS - 1);
    assign last_drain = cnt == 4'(DRAIN_CYCLES - 1);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = '0;
        col_n   = '0;
        k       = 0;
        case (state)
            IDLE:    state_n = bus.i_valid ? CLEAR : IDLE;
            CLEAR: begin
                state_n = FEED;
                cnt_n   = '0;
            end
            FEED: begin
                state_n = last_beat ? DRAIN : FEED;
                cnt_n   = last_beat ? 4'd0 : cnt + 4'd1;
            end
            DRAIN: begin
                state_n = last_drain ? DONE : DRAIN;
                cnt_n   = last_drain ? 4'd0 : cnt + 4'd1;
            end
            DONE:    state_n = bus.i_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        // Feeds are computed for the beat about to start so they can be registered;
        // lane i lags by i beats, giving the diagonal wavefront the array expects.
        for (int i = 0; i < 4; i++) begin
            k = int'(cnt_n) - i;
            if (state_n == FEED && k >= 0 && k < 4) begin
                row_n[i] = a_q[i][k[1:0]];
                col_n[i] = b_q[k[1:0]][i];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state           <= IDLE;
            cnt             <= '0;
            a_q             <= '0;
            b_q             <= '0;
            bus.o_c         <= '0;
            bus.o_row       <= '0;
            bus.o_col       <= '0;
            bus.o_clear     <= 1'b0;
            bus.o_doProcess <= 1'b0;
            bus.o_valid     <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_ready     <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && bus.i_valid) begin
                a_q <= bus.i_a;
                b_q <= bus.i_b;
            end
            if (state == DRAIN && last_drain) bus.o_c <= bus.i_c;
            bus.o_row       <= row_n;
            bus.o_col       <= col_n;
            bus.o_clear     <= state_n == CLEAR;
            bus.o_doProcess <= state_n == FEED || state_n == DRAIN;
            bus.o_valid     <= state_n == DONE;
            bus.o_busy      <= state_n != IDLE;
            bus.o_ready     <= state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: directed checks of the systolic array controller driving a behavioural 4x4 PE array
`define CHECK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end
module tb_systolic_array_ctrl;
    typedef logic [3:0][3:0][7:0]  m8_t;
    typedef logic [3:0][3:0][15:0] m16_t;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    systolic_array_ctrl_if bus();
    systolic_array_ctrl #(.N(4), .DRAIN_CYCLES(2)) dut (.i_clk(clk), .i_arst(arst), .bus(bus));
    logic [7:0]  ar [4][4];
    logic [7:0]  br [4][4];
    logic [7:0]  ain [4][4];
    logic [7:0]  bin [4][4];
    logic [15:0] acc [4][4] = '{default: 16'd0};
    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ain[i][j] = (j == 0) ? bus.o_row[i] : ar[i][(j + 3) % 4];
                bin[i][j] = (i == 0) ? bus.o_col[j] : br[(i + 3) % 4][j];
                bus.i_c[i][j] = acc[i][j];
            end
    end
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (bus.o_clear) begin
                    ar[i][j]  <= 8'd0;
                    br[i][j]  <= 8'd0;
                    acc[i][j] <= 16'd0;
                end else if (bus.o_doProcess) begin
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + 16'(ain[i][j]) * 16'(bin[i][j]);
                end
    end
    function automatic m16_t mm(m8_t a, m8_t b);
        m16_t c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    c[i][j] = c[i][j] + 16'(a[i][k]) * 16'(b[k][j]);
        return c;
    endfunction
    function automatic m8_t rnd();
        m8_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = 8'($urandom);
        return m;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid(inout int cyc);
        while (bus.o_valid !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
    endtask
    initial begin
        m8_t             ma, mb, m2a, m2b;
        logic [3:0][7:0] c0, c3, r3, r6, r9;
        logic [2:0]      dr;
        int              cyc, bad;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        step();
        step();
        `CHECK("reset_flags", {bus.o_ready, bus.o_busy, bus.o_valid, bus.o_clear, bus.o_doProcess}, 5'b10000)
        `CHECK("reset_feeds", {bus.o_row, bus.o_col}, 64'd0)
        `CHECK("reset_oc", bus.o_c, m16_t'(0))
        arst = 1'b0;
        step();
        `CHECK("idle_ready", bus.o_ready, 1'b1)
        // identity job
        ma = '0;
        for (int i = 0; i < 4; i++) ma[i][i] = 8'd1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                mb[k][j] = 8'(4 * k + j + 1);
        bus.i_a = ma;
        bus.i_b = mb;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        cyc = 1;
        `CHECK("clear_cycle", {bus.o_clear, bus.o_doProcess, bus.o_ready, bus.o_busy}, 4'b1001)
        c0 = '0; c3 = '0; dr = '0;
        while (bus.o_valid !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
            if (cyc == 2) c0 = bus.o_col;
            if (cyc == 5) c3 = bus.o_col;
            if (cyc == 13) dr = {bus.o_doProcess, bus.o_row == 32'd0, bus.o_col == 32'd0};
        end
        `CHECK("id_latency", cyc, 14)
        `CHECK("id_col_t0", c0, {8'd0, 8'd0, 8'd0, 8'd1})
        `CHECK("id_col_t3", c3, {8'd4, 8'd7, 8'd10, 8'd13})
        `CHECK("id_drain", dr, 3'b111)
        `CHECK("id_c23", bus.o_c[2][3], 16'd12)
        `CHECK("id_c30", bus.o_c[3][0], 16'd13)
        `CHECK("id_matrix", bus.o_c, mm(ma, mb))
        bus.i_ready = 1'b1;
        step();
        `CHECK("id_accept", {bus.o_valid, bus.o_ready, bus.o_busy}, 3'b010)
        `CHECK("id_retain", bus.o_c, mm(ma, mb))
        bus.i_ready = 1'b0;
        // wrap job, then backpressure on its result
        bus.i_a = '1;
        bus.i_b = '1;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        cyc = 1;
        wait_valid(cyc);
        `CHECK("wrap_valid", bus.o_valid, 1'b1)
        `CHECK("wrap_c12", bus.o_c[1][2], 16'd63492)
        `CHECK("wrap_matrix", bus.o_c, {16{16'd63492}})
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            bus.i_valid = (n == 5);
            bus.i_a = rnd();
            step();
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_c !== {16{16'd63492}}) bad++;
        end
        bus.i_valid = 1'b0;
        `CHECK("bp_stable", bad, 0)
        bus.i_ready = 1'b1;
        step();
        `CHECK("bp_release", {bus.o_valid, bus.o_ready}, 2'b01)
        `CHECK("bp_retain", bus.o_c, {16{16'd63492}})
        bus.i_ready = 1'b0;
        step();
        `CHECK("bp_no_job", bus.o_busy, 1'b0)
        // skew job
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                ma[i][k] = 8'(16 * i + k + 1);
        bus.i_a = ma;
        bus.i_b = '0;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        cyc = 1;
        r3 = 'x; r6 = 'x; r9 = 'x;
        while (bus.o_valid !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
            if (cyc == 5) r3 = bus.o_row;
            if (cyc == 8) r6 = bus.o_row;
            if (cyc == 11) r9 = bus.o_row;
        end
        `CHECK("skew_t3", r3, {8'd49, 8'd34, 8'd19, 8'd4})
        `CHECK("skew_t6", r6, {8'd52, 8'd0, 8'd0, 8'd0})
        `CHECK("skew_t9", r9, 32'd0)
        `CHECK("skew_result", bus.o_c, m16_t'(0))
        bus.i_ready = 1'b1;
        step();
        // back-to-back jobs with i_valid held high
        ma = rnd(); mb = rnd(); m2a = rnd(); m2b = rnd();
        bus.i_a = ma;
        bus.i_b = mb;
        bus.i_valid = 1'b1;
        step();
        bus.i_a = m2a;
        bus.i_b = m2b;
        cyc = 1;
        wait_valid(cyc);
        `CHECK("b2b_first", bus.o_c, mm(ma, mb))
        step();
        `CHECK("b2b_idle", {bus.o_ready, bus.o_valid}, 2'b10)
        step();
        `CHECK("b2b_second_hs", bus.o_clear, 1'b1)
        bus.i_valid = 1'b0;
        cyc = 1;
        wait_valid(cyc);
        `CHECK("b2b_latency", cyc, 14)
        `CHECK("b2b_second", bus.o_c, mm(m2a, m2b))
        step();
        bus.i_ready = 1'b0;
        // reset in the middle of FEED
        bus.i_a = rnd();
        bus.i_b = rnd();
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        for (int n = 2; n <= 7; n++) step();
        `CHECK("mid_feed", bus.o_doProcess, 1'b1)
        arst = 1'b1;
        step();
        arst = 1'b0;
        `CHECK("rst_flags", {bus.o_ready, bus.o_busy, bus.o_valid, bus.o_clear, bus.o_doProcess}, 5'b10000)
        `CHECK("rst_feeds", {bus.o_row, bus.o_col}, 64'd0)
        `CHECK("rst_oc", bus.o_c, m16_t'(0))
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (bus.o_valid !== 1'b0) bad++;
        end
        `CHECK("rst_no_valid", bad, 0)
        ma = rnd(); mb = rnd();
        bus.i_a = ma;
        bus.i_b = mb;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        `CHECK("post_rst_clear", bus.o_clear, 1'b1)
        cyc = 1;
        wait_valid(cyc);
        `CHECK("post_rst_result", bus.o_c, mm(ma, mb))
        bus.i_ready = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
